// File: rtl/fifo_pkg.sv
// Shared sizing helpers, read-mode constants and parameter legality check
// for the fifo_sync_pro family.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_ok(input int depth, input int af_level, input int ae_level);
    return (depth >= 2) && (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, contents never reset.
module fifo_ram import fifo_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_pro.sv
// Single-clock FIFO with arbitrary depth, optional FWFT output, occupancy count,
// programmable almost flags and sticky overflow/underflow errors.
module fifo_sync_pro import fifo_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int FWFT     = FIFO_STD,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     r_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $fatal(1, "fifo_sync_pro: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             wr_acc, rd_acc;
  logic             wr_drop, rd_drop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Flags decode only from the registered count.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A write into a full FIFO is accepted when a read frees the slot in the same cycle.
  assign wr_acc  = w_en && (!full || r_en);
  assign rd_acc  = r_en && !empty;
  assign wr_drop = w_en && full && !r_en;
  assign rd_drop = r_en && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error outranks a clear in the same cycle.
      if (wr_drop)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (rd_drop)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign data_out = rd_data;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= rd_data;
    end
    assign data_out = dout_q;
  end

  a_full_empty_excl: assert property (@(posedge clk) disable iff (rst) !(full && empty));

endmodule
